iram_loader: RTL
================

Name: iram_loader

Overview:
- Write-side companion to the 4-port instruction RAM.
- Accepts a byte stream from the host or debug link over a valid/ready handshake.
- Packs every 3 bytes into one 21-bit instruction and drives a single IRAM write port at sequential addresses from 0.
- Holds all four cores in halt until the requested number of words has been written.

Parameters:
INS_WIDTH, 21, instruction word width in bits
ADDR_WIDTH, 6, IRAM address width (matches PC width)
IRAM_DEPTH, 52, number of valid IRAM locations (0..51)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load of word_count words
word_count  input  ADDR_WIDTH  words to load; sampled only on accepted start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid this cycle
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  IRAM write strobe, one cycle per word
wr_addr  output  ADDR_WIDTH  IRAM write address
wr_data  output  INS_WIDTH  IRAM write data
busy  output  1  load in progress
done  output  1  level; load finished (successfully or with error)
err  output  1  sticky error flag for the last load
cores_halt  output  1  level; holds all four cores' PCs

Behaviour:
- Reset, asynchronous: state IDLE; wr_addr=0, wr_data=0; byte_ready=wr_en=busy=done=err=0; cores_halt=1.
- States: IDLE, B0, B1, B2, WRITE, DONE.
- IDLE or DONE, start=1:
  - word_count==0 or >IRAM_DEPTH: go to DONE with err=1, cores_halt=1, no writes.
  - Otherwise: latch count, wr_addr=0, clear done/err, cores_halt=1, busy=1, go to B0.
- start while busy: ignored, no effect.
- byte_ready=1 only in B0, B1, B2. A byte is accepted on a cycle with byte_valid&&byte_ready; otherwise the state holds, with any number of stall cycles.
- Byte order, big-endian:
  - B0: wr_data[20:16]=byte_in[4:0]. If byte_in[7:5]!=0, set err (sticky); the word is still written with the upper bits dropped.
  - B1: wr_data[15:8]=byte_in.
  - B2: wr_data[7:0]=byte_in, then go to WRITE.
- WRITE, exactly one cycle: wr_en=1, byte_ready=0, wr_addr and wr_data stable and valid.
  - Latency: wr_en is asserted the cycle after the third byte is accepted.
  - Next cycle: if wr_addr==count-1, go to DONE and leave wr_addr unchanged. Otherwise wr_addr+1, go to B0.
- wr_addr never exceeds IRAM_DEPTH-1; there is no wrap-around.
- DONE: busy=0, done=1, byte_ready=0. cores_halt=0 if err==0, else cores_halt stays 1.
- A new start from DONE restarts the load and reasserts cores_halt in the same cycle the start is accepted.
- wr_en is never asserted outside WRITE.
- Reset mid-load aborts immediately. Words already written stay in IRAM; no partial word is written.
- byte_valid with byte_ready=0 (IDLE, WRITE, DONE): byte is not consumed; the source must hold it.

Decomposition:
- Shared package (processor-wide): INS_WIDTH, ADDR_WIDTH, IRAM_DEPTH constants and the loader state enum.
- One natural sub-module, iram_word_packer:
  - 3-byte shift/assembly register with a byte index.
  - Flags a header-bits error on byte 0.
  - Asserts word_ready after byte 2.
- The FSM, address counter and halt/done logic stay in iram_loader.

Test Plan:
- Load count=2, bytes 0x06,0x10,0x00,0x06,0x24,0x00 with back-to-back valid:
  - Required: wr_en pulses at addr 0 with 21'h061000, then at addr 1 with 21'h062400.
  - Then done=1, err=0, cores_halt=0.
- Same load with byte_valid toggling every other cycle: identical writes, one wr_en each, byte_ready=0 during each WRITE cycle.
- Load count=1, first byte 0xE1: err=1, wr_data[20:16]=5'h01 written at addr 0, cores_halt stays 1.
- start with word_count=0, and again with word_count=53: immediately done=1, err=1, wr_en never asserted.
- Load count=52: last write at addr 51, then DONE; no write at addr 52. A start pulse mid-load is ignored.
- Assert rst after the second byte of word 3: all outputs return to reset values asynchronously; no wr_en for word 3; a fresh start reloads from addr 0.

Source files
------------

// File: rtl/iram_loader_pkg.sv
// -----------------------------------------------------------------------------
// iram_loader_pkg
//   Processor-wide constants shared by the IRAM and its loader. The package
//   also holds the loader state encoding and a start-count legality helper.
//   No ports; imported with `import iram_loader_pkg::*;`.
// -----------------------------------------------------------------------------
package iram_loader_pkg;

    localparam int INS_WIDTH  = 21;  // instruction word width
    localparam int ADDR_WIDTH = 6;   // IRAM address / PC width
    localparam int IRAM_DEPTH = 52;  // valid locations 0..51

    localparam logic [ADDR_WIDTH-1:0] IRAM_DEPTH_W = ADDR_WIDTH'(IRAM_DEPTH);

    typedef logic [2:0] loader_state_t;

    // Loader FSM encoding; also visible on the debug state output.
    localparam loader_state_t ST_IDLE  = 3'd0;
    localparam loader_state_t ST_B0    = 3'd1;
    localparam loader_state_t ST_B1    = 3'd2;
    localparam loader_state_t ST_B2    = 3'd3;
    localparam loader_state_t ST_WRITE = 3'd4;
    localparam loader_state_t ST_DONE  = 3'd5;

    // A load request is legal only for 1..IRAM_DEPTH words.
    function automatic logic count_valid(input logic [ADDR_WIDTH-1:0] count);
        return (count != '0) && (count <= IRAM_DEPTH_W);
    endfunction

endpackage

// File: rtl/iram_loader_if.sv
// -----------------------------------------------------------------------------
// iram_loader_if
//   Groups the byte-stream handshake and the IRAM write port.
//   Signals:
//     byte_in[7:0], byte_valid  stream from host/debug link
//     byte_ready                loader can take a byte this cycle
//     wr_en, wr_addr, wr_data   single IRAM write port
//   Modports:
//     master : byte source / IRAM-side observer (drives the stream)
//     slave  : the loader (consumes the stream, drives the write port)
//
//   Handshake: a byte transfers on a rising clk edge where byte_valid and
//   byte_ready are both 1. While byte_valid is 1 and the byte has not
//   transferred, the source must hold byte_in stable. byte_ready depends
//   only on loader state, never on byte_valid.
// -----------------------------------------------------------------------------
interface iram_loader_if;
    import iram_loader_pkg::*;

    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [INS_WIDTH-1:0]  wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/iram_word_packer.sv
// -----------------------------------------------------------------------------
// iram_word_packer
//   Assembles three big-endian bytes into one instruction word.
//   Ports:
//     clk, rst      clock, async active-high reset
//     clear         restart assembly at byte 0 (new load)
//     byte_fire     byte_in is accepted this cycle
//     byte_in[7:0]  stream byte
//     word          assembled instruction (held until overwritten)
//     hdr_err       byte 0 accepted with nonzero bits [7:5]
//     word_ready    third byte accepted this cycle
// -----------------------------------------------------------------------------
module iram_word_packer
    import iram_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_fire,
    input  logic [7:0]           byte_in,
    output logic [INS_WIDTH-1:0] word,
    output logic                 hdr_err,
    output logic                 word_ready
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= '0;
            byte_idx <= 2'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (byte_fire) begin
            case (byte_idx)
                2'd0: begin
                    // Upper three bits of byte 0 have no home in a 21-bit word.
                    word[INS_WIDTH-1:16] <= byte_in[INS_WIDTH-17:0];
                    byte_idx             <= 2'd1;
                end
                2'd1: begin
                    word[15:8] <= byte_in;
                    byte_idx   <= 2'd2;
                end
                default: begin
                    word[7:0] <= byte_in;
                    byte_idx  <= 2'd0;
                end
            endcase
        end
    end

    assign hdr_err    = byte_fire && (byte_idx == 2'd0) && (byte_in[7:5] != 3'd0);
    assign word_ready = byte_fire && (byte_idx == 2'd2);

endmodule

// File: rtl/iram_loader.sv
// -----------------------------------------------------------------------------
// iram_loader
//   Loads word_count instructions from a byte stream into the IRAM at
//   addresses 0..word_count-1 and keeps the cores halted until a clean load
//   completes.
//   Ports:
//     clk, rst        clock, async active-high reset
//     start           one-cycle load request (ignored while busy)
//     word_count      words to load, sampled on an accepted start
//     bus             stream in / IRAM write port (slave side)
//     busy            load in progress
//     done            load finished (ok or error), level
//     err             sticky error for the last load
//     cores_halt      holds all four cores' PCs
//     state_dbg       current FSM state
// -----------------------------------------------------------------------------
module iram_loader
    import iram_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_count,
    iram_loader_if.slave          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cores_halt,
    output loader_state_t         state_dbg
);

    loader_state_t         state;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  err_q;

    logic                  byte_fire;
    logic                  load_ok;
    logic                  hdr_err;
    logic                  word_ready;
    logic [INS_WIDTH-1:0]  word;

    assign byte_fire = bus.byte_valid && bus.byte_ready;
    assign load_ok   = start && ((state == ST_IDLE) || (state == ST_DONE))
                       && count_valid(word_count);

    iram_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_ok),
        .byte_fire  (byte_fire),
        .byte_in    (bus.byte_in),
        .word       (word),
        .hdr_err    (hdr_err),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (count_valid(word_count)) begin
                            count_q <= word_count;
                            addr_q  <= '0;
                            err_q   <= 1'b0;
                            state   <= ST_B0;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_B0: begin
                    if (hdr_err) err_q <= 1'b1;
                    if (byte_fire) state <= ST_B1;
                end
                ST_B1: begin
                    if (byte_fire) state <= ST_B2;
                end
                ST_B2: begin
                    if (word_ready) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // count_q <= IRAM_DEPTH, so addr_q stops at IRAM_DEPTH-1 at most.
                    if (addr_q == count_q - 1'b1) begin
                        state <= ST_DONE;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        state  <= ST_B0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = (state == ST_B0) || (state == ST_B1) || (state == ST_B2);
    assign bus.wr_en      = (state == ST_WRITE);
    assign bus.wr_addr    = addr_q;
    assign bus.wr_data    = word;

    assign busy      = bus.byte_ready || (state == ST_WRITE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;
    // Cores run only after a clean load; a start from DONE re-halts them at once.
    assign cores_halt = !((state == ST_DONE) && !err_q) || start;
    assign state_dbg  = state;

endmodule
